obi_wb_arbiter_bridge: RTL and testbench
========================================

// Module: obi_wb_arbiter_bridge
// PURPOSE
//  Parametrised bridge that collects NUM_PORTS OBI master ports (e.g. core instr + data)
//  and arbitrates them round-robin onto one Wishbone classic master toward the Controller.
//  Generalises the fixed instr/data-to-Wishbone glue of the processor tops: any port count,
//  widths, byte-enables, and an optional bus-hang timeout. One transaction in flight at a time.
// PARAMETERS
//  NUM_PORTS       2     number of OBI slave ports (1..8)
//  ADDR_W          32    address width
//  DATA_W          32    data width (multiple of 8); SEL_W = DATA_W/8
//  TIMEOUT_CYCLES  1024  BUS-state cycles before forced termination (OBI_WB_TIMEOUT_EN only)
// PORTS
//  clk            in   1               system clock, all logic on rising edge
//  rst_n          in   1               asynchronous active-low reset
//  obi_req_i      in   NUM_PORTS       per-port request
//  obi_gnt_o      out  NUM_PORTS       per-port grant (one-hot or zero)
//  obi_addr_i     in   NUM_PORTS*ADDR_W  packed addresses, port p at [p*ADDR_W +: ADDR_W]
//  obi_we_i       in   NUM_PORTS       1 = write
//  obi_be_i       in   NUM_PORTS*SEL_W packed byte enables
//  obi_wdata_i    in   NUM_PORTS*DATA_W packed write data
//  obi_rvalid_o   out  NUM_PORTS       per-port response valid (one-hot or zero)
//  obi_rdata_o    out  NUM_PORTS*DATA_W packed read data (same value broadcast to all ports)
//  wb_cyc_o       out  1               Wishbone cycle
//  wb_stb_o       out  1               Wishbone strobe (== wb_cyc_o)
//  wb_we_o        out  1               Wishbone write enable
//  wb_sel_o       out  SEL_W           Wishbone byte select
//  wb_addr_o      out  ADDR_W          Wishbone address
//  wb_data_o      out  DATA_W          Wishbone write data
//  wb_data_i      in   DATA_W          Wishbone read data
//  wb_ack_i       in   1               Wishbone acknowledge
//  timeout_o      out  1               one-cycle pulse on forced termination
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0 (gnt, rvalid, cyc, stb, we,
//   sel, addr, data, rdata, timeout). Reset mid-transaction abandons it; no rvalid issued.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  IDLE: if any obi_req_i, winner = first requesting port scanning rr_ptr, rr_ptr+1, ...
//   (mod NUM_PORTS). obi_gnt_o[winner]=1 combinationally same cycle; on that edge latch
//   owner, addr, we, be, wdata; rr_ptr <= (winner+1) mod NUM_PORTS; go BUS. No req: stay.
//  BUS: wb_cyc_o=wb_stb_o=1, wb_* driven from latched regs, stable until ack. On wb_ack_i:
//   capture wb_data_i (reads) or 0 (writes) into rdata reg, drop cyc/stb next cycle, go RESP.
//  RESP: obi_rvalid_o[owner]=1 for exactly one cycle, rdata valid; no grants; -> IDLE.
//  Latency: grant to rvalid = 2 + Wishbone wait cycles (ack in first BUS cycle -> rvalid 2
//   cycles after grant edge). Max throughput one transaction per 3 cycles.
//  No grant is given outside IDLE; wb_ack_i outside BUS is ignored.
//  Requests dropped by non-owners mid-transaction have no effect; owner req is not resampled.
//  NUM_PORTS=1: arbiter degenerates, rr_ptr stays 0.
// CONFIGURATION
//  OBI_WB_TIMEOUT_EN defined: cycle counter cleared on entry to BUS, increments each BUS
//   cycle without ack; when it reaches TIMEOUT_CYCLES, drop cyc/stb, load rdata with
//   32'hDEAD_BEEF (replicated/truncated to DATA_W), pulse timeout_o, go RESP. If ack and
//   timeout coincide, ack wins and timeout_o stays 0.
//  Not defined: no counter, BUS waits for ack indefinitely, timeout_o tied to 0.
// TESTING
//  1 Reset: hold rst_n=0 with req=2'b11, wb_ack_i=1 -> all outputs 0; release -> port0 granted.
//  2 Port0 read 0x1000, ack in 1st BUS cycle with 0xCAFEF00D -> gnt[0] 1 cycle,
//    cyc/stb 1 cycle, rvalid[0] 2 cycles after grant edge, rdata=0xCAFEF00D.
//  3 Both ports request continuously -> grants alternate 0,1,0,1; each rvalid to grant owner.
//  4 Port1 write 0x2004 data 0x12345678 be 4'b0011, ack after 5 waits -> wb_we=1,
//    sel=0011, addr/data stable 6 cycles; rvalid[1] with rdata=0.
//  5 OBI_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, never ack -> cyc drops after 16 BUS cycles,
//    timeout_o pulse, rvalid with 0xDEADBEEF; variant ack on cycle 16 -> ack data, no timeout.
//  6 Assert rst_n=0 during BUS -> cyc/stb drop immediately, no rvalid, next grant to port0.

Source files
------------

// File: rtl/obi_wb_arbiter_bridge.sv
// Purpose : round-robin arbiter folding NUM_PORTS OBI masters onto one Wishbone classic master.
// Latency : grant to rvalid = 2 + Wishbone wait cycles; one transaction in flight, at most one per 3 cycles.
// Backpressure: ports are held off by withholding grant outside IDLE; Wishbone stalls by delaying ack.
//           Optional bus-hang timeout enabled by defining OBI_WB_TIMEOUT_EN.
module obi_wb_arbiter_bridge #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          obi_req_i,
    output logic [NUM_PORTS-1:0]          obi_gnt_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]   obi_addr_i,
    input  logic [NUM_PORTS-1:0]          obi_we_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] obi_be_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   obi_wdata_i,
    output logic [NUM_PORTS-1:0]          obi_rvalid_o,
    output logic [NUM_PORTS*DATA_W-1:0]   obi_rdata_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    output logic                          wb_we_o,
    output logic [DATA_W/8-1:0]           wb_sel_o,
    output logic [ADDR_W-1:0]             wb_addr_o,
    output logic [DATA_W-1:0]             wb_data_o,
    input  logic [DATA_W-1:0]             wb_data_i,
    input  logic                          wb_ack_i,
    output logic                          timeout_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          owner;
    logic [PW-1:0]          winner;
    logic [PW-1:0]          next_ptr;
    logic                   any_req;
    logic [NUM_PORTS-1:0]   owner_oh;
    logic [NUM_PORTS-1:0]   rvalid_q;
    logic                   cyc_q;
    logic                   we_q;
    logic [SEL_W-1:0]       sel_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata_q;

`ifdef OBI_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // 0xDEADBEEF repeated across the data bus, cut off at DATA_W bits
    function automatic logic [DATA_W-1:0] dead_fill();
        logic [31:0]       c;
        logic [DATA_W-1:0] r;
        c = 32'hDEAD_BEEF;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = c[i % 32];
        end
        return r;
    endfunction

    localparam logic [DATA_W-1:0] DEAD_PAT = dead_fill();

    logic [CW-1:0] cnt;
    logic          timeout_q;
`endif

    assign any_req = |obi_req_i;

    // First requester found scanning upward from the round-robin pointer
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!found && obi_req_i[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time
    always_comb begin
        if (int'(winner) >= NUM_PORTS - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + PW'(1);
        end
    end

    // Grant is combinational and only ever offered while idle and out of reset
    always_comb begin
        obi_gnt_o = '0;
        if (rst_n && (state == IDLE) && any_req) begin
            obi_gnt_o[winner] = 1'b1;
        end
    end

    // One-hot of the port that owns the transaction in flight
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    // Transaction FSM: latch request, run the Wishbone cycle, return one response beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rvalid_q  <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef OBI_WB_TIMEOUT_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            rvalid_q  <= '0;
`ifdef OBI_WB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        addr_q  <= obi_addr_i[winner*ADDR_W +: ADDR_W];
                        we_q    <= obi_we_i[winner];
                        sel_q   <= obi_be_i[winner*SEL_W +: SEL_W];
                        wdata_q <= obi_wdata_i[winner*DATA_W +: DATA_W];
                        rr_ptr  <= next_ptr;
                        cyc_q   <= 1'b1;
`ifdef OBI_WB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                        state   <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        // writes return zero data so the master never sees stale read data
                        cyc_q    <= 1'b0;
                        rdata_q  <= we_q ? '0 : wb_data_i;
                        rvalid_q <= owner_oh;
                        state    <= RESP;
`ifdef OBI_WB_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        cyc_q     <= 1'b0;
                        rdata_q   <= DEAD_PAT;
                        rvalid_q  <= owner_oh;
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = wdata_q;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = {NUM_PORTS{rdata_q}};

`ifdef OBI_WB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_wb_arbiter_bridge.sv
module tb_obi_wb_arbiter_bridge;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      obi_req_i;
    logic [NP-1:0]      obi_gnt_o;
    logic [NP*AW-1:0]   obi_addr_i;
    logic [NP-1:0]      obi_we_i;
    logic [NP*SW-1:0]   obi_be_i;
    logic [NP*DW-1:0]   obi_wdata_i;
    logic [NP-1:0]      obi_rvalid_o;
    logic [NP*DW-1:0]   obi_rdata_o;
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [SW-1:0]      wb_sel_o;
    logic [AW-1:0]      wb_addr_o;
    logic [DW-1:0]      wb_data_o;
    logic [DW-1:0]      wb_data_i;
    logic               wb_ack_i;
    logic               timeout_o;

    obi_wb_arbiter_bridge #(
        .NUM_PORTS     (NP),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .obi_req_i   (obi_req_i),
        .obi_gnt_o   (obi_gnt_o),
        .obi_addr_i  (obi_addr_i),
        .obi_we_i    (obi_we_i),
        .obi_be_i    (obi_be_i),
        .obi_wdata_i (obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o),
        .obi_rdata_o (obi_rdata_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;   // reference round-robin pointer

    logic [AW-1:0] paddr [NP];
    logic          pwe   [NP];
    logic [SW-1:0] pbe   [NP];
    logic [DW-1:0] pwd   [NP];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_ports();
        for (int p = 0; p < NP; p++) begin
            paddr[p] = $urandom;
            pwe[p]   = 1'($urandom_range(0, 1));
            pbe[p]   = SW'($urandom);
            pwd[p]   = $urandom;
        end
    endtask

    task automatic drive_ports(input logic [NP-1:0] mask);
        obi_req_i = mask;
        for (int p = 0; p < NP; p++) begin
            obi_addr_i[p*AW +: AW]  = paddr[p];
            obi_we_i[p]             = pwe[p];
            obi_be_i[p*SW +: SW]    = pbe[p];
            obi_wdata_i[p*DW +: DW] = pwd[p];
        end
    endtask

    // One full transaction: grant check, Wishbone slave with wait_n wait states, response check
    task automatic run_txn(input logic [NP-1:0] mask, input int wait_n, input logic [DW-1:0] rd);
        int            w;
        int            bus_n;
        bit            to_hit;
        logic [NP-1:0] oh;
        logic [DW-1:0] exp_rd;
        w = -1;
        for (int i = 0; i < NP; i++) begin
            int idx;
            idx = (mptr + i) % NP;
            if (w < 0 && mask[idx]) w = idx;
        end
        oh    = '0;
        oh[w] = 1'b1;
        wb_ack_i = 1'b0;
        drive_ports(mask);
        #1;
        chk("idle_gnt", obi_gnt_o, oh);
        chk("idle_cyc", wb_cyc_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        mptr   = (w + 1) % NP;
        bus_n  = wait_n + 1;
        to_hit = 1'b0;
`ifdef OBI_WB_TIMEOUT_EN
        if (wait_n >= TO) begin
            bus_n  = TO;
            to_hit = 1'b1;
        end
`endif
        for (int k = 1; k <= bus_n; k++) begin
            chk("bus_cyc", wb_cyc_o, 1'b1);
            chk("bus_stb", wb_stb_o, 1'b1);
            chk("bus_we", wb_we_o, pwe[w]);
            chk("bus_sel", wb_sel_o, pbe[w]);
            chk("bus_addr", wb_addr_o, paddr[w]);
            chk("bus_wdata", wb_data_o, pwd[w]);
            chk("bus_gnt", obi_gnt_o, '0);
            chk("bus_rvalid", obi_rvalid_o, '0);
            chk("bus_timeout", timeout_o, 1'b0);
            obi_req_i = NP'($urandom);
            wb_ack_i  = (!to_hit && k == bus_n);
            wb_data_i = wb_ack_i ? rd : $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        exp_rd = to_hit ? 32'hDEAD_BEEF : (pwe[w] ? '0 : rd);
        chk("resp_cyc", wb_cyc_o, 1'b0);
        chk("resp_stb", wb_stb_o, 1'b0);
        chk("resp_rvalid", obi_rvalid_o, oh);
        chk("resp_rdata", obi_rdata_o, {NP{exp_rd}});
        chk("resp_timeout", timeout_o, to_hit);
        chk("resp_gnt", obi_gnt_o, '0);
        // stray ack while idle must be ignored
        obi_req_i = '0;
        wb_ack_i  = 1'b1;
        wb_data_i = $urandom;
        @(posedge clk);
        @(negedge clk);
        chk("post_rvalid", obi_rvalid_o, '0);
        chk("post_timeout", timeout_o, 1'b0);
        chk("post_cyc", wb_cyc_o, 1'b0);
        wb_ack_i = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        obi_req_i   = '0;
        obi_addr_i  = '0;
        obi_we_i    = '0;
        obi_be_i    = '0;
        obi_wdata_i = '0;
        wb_data_i   = '0;
        wb_ack_i    = 1'b0;
        rand_ports();

        // reset with requests and ack asserted: everything quiet
        paddr[0] = 32'h0000_1000;
        pwe[0]   = 1'b0;
        drive_ports(3'b011);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        chk("rst_gnt", obi_gnt_o, '0);
        chk("rst_rvalid", obi_rvalid_o, '0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_sel", wb_sel_o, '0);
        chk("rst_addr", wb_addr_o, '0);
        chk("rst_wdata", wb_data_o, '0);
        chk("rst_rdata", obi_rdata_o, '0);
        chk("rst_timeout", timeout_o, 1'b0);
        wb_ack_i = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rel_gnt", obi_gnt_o, 3'b001);

        // port0 read, ack in first bus cycle
        run_txn(3'b011, 0, 32'hCAFE_F00D);

        // both ports requesting continuously: grants alternate
        for (int i = 0; i < 4; i++) begin
            rand_ports();
            run_txn(3'b011, $urandom_range(0, 2), $urandom);
        end

        // port1 write with five wait states
        paddr[1] = 32'h0000_2004;
        pwe[1]   = 1'b1;
        pwd[1]   = 32'h1234_5678;
        pbe[1]   = 4'b0011;
        run_txn(3'b010, 5, 32'h9999_9999);

        // long stall (forced termination when the timeout is built in)
        pwe[2] = 1'b0;
        run_txn(3'b100, 20, 32'h0BAD_F00D);
        // ack lands exactly on the last allowed bus cycle
        pwe[0] = 1'b0;
        run_txn(3'b001, TO - 1, 32'hA5A5_0001);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [NP-1:0] m;
            rand_ports();
            m = NP'($urandom_range(1, (1 << NP) - 1));
            run_txn(m, $urandom_range(0, 3), $urandom);
        end

        // reset in the middle of a bus cycle
        rand_ports();
        drive_ports(3'b110);
        @(posedge clk);
        @(negedge clk);
        chk("mid_cyc_before", wb_cyc_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_cyc", wb_cyc_o, 1'b0);
        chk("mid_stb", wb_stb_o, 1'b0);
        chk("mid_gnt", obi_gnt_o, '0);
        chk("mid_rvalid", obi_rvalid_o, '0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rvalid_hold", obi_rvalid_o, '0);
        mptr  = 0;
        rst_n = 1'b1;
        run_txn(3'b111, 1, 32'h7777_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
